// File: rtl/ddr3_app_arbiter.sv
// ddr3_app_arbiter
// Two-master round-robin arbiter in front of the DDR3 controller app port.
// The winning master's cmd/addr/wdata/wmask are latched in IDLE and presented
// in ISSUE until the controller accepts them. A per-read tag FIFO records
// which master issued each read, so returned data reaches the right master.
//
// Ports
//   i_clk, i_rst                 clock (clk_x1), synchronous active-high reset
//   i_init_calib_complete        no command is issued while low
//   i_mN_req/cmd/addr/wdata/wmask  master N request bundle (held until o_mN_gnt)
//   o_mN_gnt                     accept pulse, same cycle as the controller accept
//   o_mN_rdata/o_mN_rvalid       read return (shared data bus, per-master valid)
//   i_app_rdy, i_app_wdf_rdy     controller command / write-data ready
//   o_app_en/cmd/addr            command to controller
//   o_app_wdf_wren/end/data/mask single-beat write data
//   i_app_rd_data(_valid)        read data from controller
//   o_app_ref_req/o_app_sre_req  refresh / self-refresh request (sre tied low)
//   i_app_ref_ack                refresh acknowledge
//   o_tag_err                    sticky: read data arrived with no outstanding tag
//
// Configuration
//   ARB_REFRESH_EN  when defined, a free-running counter raises a refresh request
//                   every REF_INTERVAL cycles; otherwise o_app_ref_req is tied low.

module ddr3_app_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 29,
   parameter int unsigned DATA_WIDTH   = 64,
   parameter int unsigned MASK_WIDTH   = 8,
   parameter int unsigned TAG_DEPTH    = 16,
   parameter int unsigned REF_INTERVAL = 1560
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_init_calib_complete,
   input  logic                  i_m0_req,
   input  logic [2:0]            i_m0_cmd,
   input  logic [ADDR_WIDTH-1:0] i_m0_addr,
   input  logic [DATA_WIDTH-1:0] i_m0_wdata,
   input  logic [MASK_WIDTH-1:0] i_m0_wmask,
   output logic                  o_m0_gnt,
   output logic [DATA_WIDTH-1:0] o_m0_rdata,
   output logic                  o_m0_rvalid,
   input  logic                  i_m1_req,
   input  logic [2:0]            i_m1_cmd,
   input  logic [ADDR_WIDTH-1:0] i_m1_addr,
   input  logic [DATA_WIDTH-1:0] i_m1_wdata,
   input  logic [MASK_WIDTH-1:0] i_m1_wmask,
   output logic                  o_m1_gnt,
   output logic [DATA_WIDTH-1:0] o_m1_rdata,
   output logic                  o_m1_rvalid,
   input  logic                  i_app_rdy,
   input  logic                  i_app_wdf_rdy,
   output logic                  o_app_en,
   output logic [2:0]            o_app_cmd,
   output logic [ADDR_WIDTH-1:0] o_app_addr,
   output logic                  o_app_wdf_wren,
   output logic                  o_app_wdf_end,
   output logic [DATA_WIDTH-1:0] o_app_wdf_data,
   output logic [MASK_WIDTH-1:0] o_app_wdf_mask,
   input  logic [DATA_WIDTH-1:0] i_app_rd_data,
   input  logic                  i_app_rd_data_valid,
   output logic                  o_app_ref_req,
   output logic                  o_app_sre_req,
   input  logic                  i_app_ref_ack,
   output logic                  o_tag_err
);

   localparam int unsigned TAG_AW = $clog2(TAG_DEPTH);
   localparam int unsigned CNT_W  = TAG_AW + 1;
   localparam logic [2:0]  CMD_WR = 3'b000;
   localparam logic [2:0]  CMD_RD = 3'b001;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_REF} state_t;

   state_t                r_state;
   logic                  r_rr;        // last granted master; the other wins a tie
   logic                  r_win;       // master owning the command in ISSUE
   logic                  r_is_wr;
   logic                  r_app_en;
   logic [2:0]            r_app_cmd;
   logic [ADDR_WIDTH-1:0] r_app_addr;
   logic                  r_wdf_wren;
   logic [DATA_WIDTH-1:0] r_wdf_data;
   logic [MASK_WIDTH-1:0] r_wdf_mask;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_m0_rvalid;
   logic                  r_m1_rvalid;
   logic                  r_tag_err;
   logic [TAG_DEPTH-1:0]  r_tags;
   logic [TAG_AW-1:0]     r_wr_ptr;
   logic [TAG_AW-1:0]     r_rd_ptr;
   logic [CNT_W-1:0]      r_count;

   logic w_m0_wr, w_m1_wr, w_full, w_m0_elig, w_m1_elig, w_any;
   logic w_win, w_win_wr, w_accept, w_push, w_pop, w_head, w_ref_pend;

   // Arbitration: writes are always eligible, reads need a free tag slot
   assign w_m0_wr   = (i_m0_cmd == CMD_WR);
   assign w_m1_wr   = (i_m1_cmd == CMD_WR);
   assign w_full    = (r_count == CNT_W'(TAG_DEPTH));
   assign w_m0_elig = i_m0_req && (w_m0_wr || !w_full);
   assign w_m1_elig = i_m1_req && (w_m1_wr || !w_full);
   assign w_any     = w_m0_elig || w_m1_elig;
   assign w_win     = (w_m0_elig && w_m1_elig) ? ~r_rr : w_m1_elig;
   assign w_win_wr  = w_win ? w_m1_wr : w_m0_wr;

   // Writes need both command and write-data ready in the same cycle
   assign w_accept  = (r_state == S_ISSUE) && i_app_rdy && (!r_is_wr || i_app_wdf_rdy);
   assign o_m0_gnt  = w_accept && !r_win;
   assign o_m1_gnt  = w_accept && r_win;

   // Tag FIFO push on accepted read, pop on returned data
   assign w_push = w_accept && !r_is_wr;
   assign w_pop  = i_app_rd_data_valid && (r_count != '0);
   assign w_head = r_tags[r_rd_ptr];

   assign o_app_en       = r_app_en;
   assign o_app_cmd      = r_app_cmd;
   assign o_app_addr     = r_app_addr;
   assign o_app_wdf_wren = r_wdf_wren;
   assign o_app_wdf_end  = r_wdf_wren;
   assign o_app_wdf_data = r_wdf_data;
   assign o_app_wdf_mask = r_wdf_mask;
   assign o_m0_rdata     = r_rdata;
   assign o_m1_rdata     = r_rdata;
   assign o_m0_rvalid    = r_m0_rvalid;
   assign o_m1_rvalid    = r_m1_rvalid;
   assign o_tag_err      = r_tag_err;
   assign o_app_sre_req  = 1'b0;

`ifdef ARB_REFRESH_EN
   localparam int unsigned REF_CW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
   logic [REF_CW-1:0] r_ref_cnt;
   logic              r_ref_pend;
   logic              r_ref_req;
   assign w_ref_pend    = r_ref_pend;
   assign o_app_ref_req = r_ref_req;
`else
   logic w_unused_ok;
   assign w_ref_pend    = 1'b0;
   assign o_app_ref_req = 1'b0;
   assign w_unused_ok   = i_app_ref_ack ^ (REF_INTERVAL == 0);
`endif

   // Arbiter FSM, tag FIFO and read-return path
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_rr        <= 1'b1;
         r_win       <= 1'b0;
         r_is_wr     <= 1'b0;
         r_app_en    <= 1'b0;
         r_app_cmd   <= '0;
         r_app_addr  <= '0;
         r_wdf_wren  <= 1'b0;
         r_wdf_data  <= '0;
         r_wdf_mask  <= '0;
         r_rdata     <= '0;
         r_m0_rvalid <= 1'b0;
         r_m1_rvalid <= 1'b0;
         r_tag_err   <= 1'b0;
         r_tags      <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
`ifdef ARB_REFRESH_EN
         r_ref_cnt   <= '0;
         r_ref_pend  <= 1'b0;
         r_ref_req   <= 1'b0;
`endif
      end else begin
         r_m0_rvalid <= w_pop && !w_head;
         r_m1_rvalid <= w_pop && w_head;
         if (w_pop) begin
            r_rdata  <= i_app_rd_data;
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (i_app_rd_data_valid && (r_count == '0)) begin
            r_tag_err <= 1'b1;
         end
         if (w_push) begin
            r_tags[r_wr_ptr] <= r_win;
            r_wr_ptr         <= r_wr_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (w_ref_pend) begin
                  r_state <= S_REF;
`ifdef ARB_REFRESH_EN
                  r_ref_req <= 1'b1;
`endif
               end else if (i_init_calib_complete && w_any) begin
                  r_state    <= S_ISSUE;
                  r_win      <= w_win;
                  r_is_wr    <= w_win_wr;
                  r_app_en   <= 1'b1;
                  r_wdf_wren <= w_win_wr;
                  r_app_cmd  <= w_win_wr ? CMD_WR : CMD_RD;
                  r_app_addr <= w_win ? i_m1_addr  : i_m0_addr;
                  r_wdf_data <= w_win ? i_m1_wdata : i_m0_wdata;
                  r_wdf_mask <= w_win ? i_m1_wmask : i_m0_wmask;
               end
            end
            S_ISSUE: begin
               if (w_accept) begin
                  r_state    <= S_IDLE;
                  r_app_en   <= 1'b0;
                  r_wdf_wren <= 1'b0;
                  r_rr       <= r_win;
               end
            end
            S_REF: begin
`ifdef ARB_REFRESH_EN
               if (i_app_ref_ack) begin
                  r_state    <= S_IDLE;
                  r_ref_req  <= 1'b0;
                  r_ref_pend <= 1'b0;
               end
`else
               r_state <= S_IDLE;
`endif
            end
            default: r_state <= S_IDLE;
         endcase

`ifdef ARB_REFRESH_EN
         // Free-running interval counter; placed after the FSM so a wrap
         // coinciding with an acknowledge leaves a fresh request pending
         if (r_ref_cnt == REF_CW'(REF_INTERVAL - 1)) begin
            r_ref_cnt  <= '0;
            r_ref_pend <= 1'b1;
         end else begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
         end
`endif
      end
   end

endmodule
